calc_op_sequencer: RTL and testbench
====================================

Name: calc_op_sequencer

Overview:
- Top-level control FSM for the switch-driven calculator.
- Captures operand A on select and operand B plus opcode on an operation button.
- Launches a multi-cycle ALU with a start/done handshake, then holds the 32-bit result for display, with high/low half paging.
- Sits between the debounced button pulses and the shared ALU, and drives the display mux.

Parameters:
- DATA_W, 16, operand width (switch input width)
- RES_W, 32, ALU result width; must be >= 2*DATA_W
- TIMEOUT, 64, max cycles to wait in S_WAIT for alu_done before flagging an error (>= 2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- bit_input  in  DATA_W  live switch value
- b_up_add_out  in  1  one-cycle debounced pulse: add
- b_left_subtract_out  in  1  one-cycle pulse: subtract
- b_right_multiply_out  in  1  one-cycle pulse: multiply
- b_down_square_out  in  1  one-cycle pulse: square
- b_mid_select_out  in  1  one-cycle pulse: select
- alu_done  in  1  ALU completion pulse; alu_result and alu_ovf are valid in the same cycle
- alu_result  in  RES_W  ALU result
- alu_ovf  in  1  ALU overflow/underflow flag
- operand_a  out  DATA_W  registered operand A
- operand_b  out  DATA_W  registered operand B
- alu_op  out  2  00 add, 01 sub, 10 mul, 11 square (square uses operand_a only)
- alu_start  out  1  one-cycle ALU launch pulse
- display_value  out  DATA_W  value for the 7-seg driver
- display_mode  out  2  00 entering A, 01 entering B, 10 result low half, 11 result high half
- busy  out  1  high in S_START and S_WAIT
- error  out  1  high in S_ERR

Behaviour:
- Reset (async, rst_n=0):
  - State S_ENTER_A.
  - operand_a, operand_b, alu_op and the result register clear to 0.
  - alu_start, busy, error = 0; display_mode = 00.
- Outputs are registered, except display_value: a combinational mux of registered state and bit_input.
- Button priority when several pulses coincide: add > sub > mul > square > select.
- S_ENTER_A:
  - display_value = bit_input.
  - select: operand_a <= bit_input, go to S_ENTER_B.
  - Operation buttons are ignored.
- S_ENTER_B:
  - display_value = bit_input.
  - Operation button:
    - operand_b <= bit_input and alu_op <= encoding, in the same edge.
    - Go to S_START.
  - Select alone: operand_a <= bit_input (re-capture); stay in S_ENTER_B.
  - Operation and select together: the operation wins; select is dropped.
- S_START:
  - alu_start = 1 for exactly this cycle; go to S_WAIT next cycle.
  - Latency: button pulse at edge N, alu_start high during cycle N+1.
- S_WAIT:
  - All buttons ignored. operand_a, operand_b and alu_op are held stable from S_START until alu_done.
  - A wait counter starts at 0 on entry and increments each cycle.
  - alu_done with alu_ovf=0: result <= alu_result; go to S_SHOW with display_mode 10. The display updates the cycle after done.
  - alu_done with alu_ovf=1: go to S_ERR; the result register is unchanged.
  - Counter reaches TIMEOUT-1 with no alu_done: go to S_ERR.
  - alu_done in the same cycle as the timeout: done wins.
- S_SHOW:
  - display_value = result[DATA_W-1:0] in mode 10, result[2*DATA_W-1:DATA_W] in mode 11.
  - Select toggles mode 10 <-> 11.
  - Any operation button: go to S_ENTER_A with display_mode 00; the operand and result registers are retained.
- S_ERR:
  - error = 1; display_value = 16'hEEEE (all-E pattern, replicated for DATA_W).
  - Any button pulse returns to S_ENTER_A and clears error.
- alu_done outside S_WAIT is ignored.
- Reset asserted mid-operation (including S_WAIT) aborts immediately. The ALU must tolerate an abandoned start.
- Subtraction result is two's complement in RES_W, not an error. Wrap-around is not checked here; only alu_ovf flags errors.

Test Plan:
- Reset, switches 0x0005, select; switches 0x0003, add pulse -> alu_start high exactly one cycle at N+1, operand_a=0x0005, operand_b=0x0003, alu_op=00, busy=1. Return done with result 0x00000008 -> display_mode=10, display_value=0x0008.
- Multiply 0x1234 * 0x0100, ALU returns 0x00123400 -> display 0x3400; select -> mode 11, display 0x0012; select -> back to 0x3400.
- ALU never asserts done, TIMEOUT=64 -> error=1 exactly 64 cycles after entering S_WAIT, display 0xEEEE. Any button -> S_ENTER_A, error=0.
- Simultaneous mul+select pulse in S_ENTER_B -> alu_op=10, operand_a unchanged. Buttons pressed during S_WAIT -> no state or operand change.
- alu_done with alu_ovf=1 -> S_ERR. alu_done in the same cycle as the timeout -> S_SHOW. Spurious alu_done in S_ENTER_A -> ignored.
- Assert rst_n=0 asynchronously mid-S_WAIT -> all outputs 0 and display_mode=00 immediately, before the next clk edge.

Source files
------------

// File: rtl/calc_op_sequencer_if.sv
// Handshake and data bundle between the calculator sequencer, the button
// debouncers, the shared ALU and the display mux.
interface calc_op_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32
);
  logic [DATA_W-1:0] bit_input;
  logic              b_up_add_out;
  logic              b_left_subtract_out;
  logic              b_right_multiply_out;
  logic              b_down_square_out;
  logic              b_mid_select_out;
  logic              alu_done;
  logic [RES_W-1:0]  alu_result;
  logic              alu_ovf;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [1:0]        alu_op;
  logic              alu_start;
  logic [DATA_W-1:0] display_value;
  logic [1:0]        display_mode;
  logic              busy;
  logic              error;

  // Sequencer side: it launches the ALU and drives the display.
  modport master (
    input  bit_input, b_up_add_out, b_left_subtract_out, b_right_multiply_out,
           b_down_square_out, b_mid_select_out, alu_done, alu_result, alu_ovf,
    output operand_a, operand_b, alu_op, alu_start, display_value,
           display_mode, busy, error
  );

  // Environment side: switches, buttons and the ALU.
  modport slave (
    output bit_input, b_up_add_out, b_left_subtract_out, b_right_multiply_out,
           b_down_square_out, b_mid_select_out, alu_done, alu_result, alu_ovf,
    input  operand_a, operand_b, alu_op, alu_start, display_value,
           display_mode, busy, error
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// Top-level control FSM of the switch-driven calculator: captures operands
// and opcode from debounced buttons, runs the multi-cycle ALU through a
// start/done handshake, and pages the 32-bit result onto the display.
// RES_W must be at least 2*DATA_W so both display pages exist.
module calc_op_sequencer #(
  parameter int DATA_W  = 16,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  calc_op_sequencer_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_ENTER_A, S_ENTER_B, S_START, S_WAIT, S_SHOW, S_ERR
  } state_t;

  // All-E pattern (nibble 4'hE repeated), truncated to DATA_W bits.
  function automatic logic [DATA_W-1:0] err_pattern();
    logic [DATA_W-1:0] p;
    for (int i = 0; i < DATA_W; i++) p[i] = ((i % 4) != 0);
    return p;
  endfunction

  state_t            state_q, state_d;
  logic [DATA_W-1:0] operand_a_q, operand_a_d;
  logic [DATA_W-1:0] operand_b_q, operand_b_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic [1:0]        display_mode_q, display_mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              alu_start_q, alu_start_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;

  logic              op_any, btn_any;
  logic [1:0]        op_code;

  // Opcode decode with fixed priority add > sub > mul > square.
  always_comb begin
    op_any  = bus.b_up_add_out | bus.b_left_subtract_out |
              bus.b_right_multiply_out | bus.b_down_square_out;
    btn_any = op_any | bus.b_mid_select_out;
    if (bus.b_up_add_out)             op_code = 2'b00;
    else if (bus.b_left_subtract_out) op_code = 2'b01;
    else if (bus.b_right_multiply_out) op_code = 2'b10;
    else                              op_code = 2'b11;
  end

  // Next-state and next-register computation; outputs follow the next state.
  always_comb begin
    state_d        = state_q;
    operand_a_d    = operand_a_q;
    operand_b_d    = operand_b_q;
    alu_op_d       = alu_op_q;
    result_d       = result_q;
    display_mode_d = display_mode_q;
    cnt_d          = cnt_q;
    case (state_q)
      S_ENTER_A: begin
        if (bus.b_mid_select_out) begin
          operand_a_d    = bus.bit_input;
          display_mode_d = 2'b01;
          state_d        = S_ENTER_B;
        end
      end
      S_ENTER_B: begin
        // An operation outranks a coincident select, which is dropped.
        if (op_any) begin
          operand_b_d = bus.bit_input;
          alu_op_d    = op_code;
          state_d     = S_START;
        end else if (bus.b_mid_select_out) begin
          operand_a_d = bus.bit_input;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A done arriving on the timeout cycle still counts as success.
        if (bus.alu_done) begin
          if (bus.alu_ovf) begin
            state_d = S_ERR;
          end else begin
            result_d       = bus.alu_result;
            display_mode_d = 2'b10;
            state_d        = S_SHOW;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_ERR;
        end
      end
      S_SHOW: begin
        if (op_any) begin
          display_mode_d = 2'b00;
          state_d        = S_ENTER_A;
        end else if (bus.b_mid_select_out) begin
          display_mode_d = {1'b1, ~display_mode_q[0]};
        end
      end
      S_ERR: begin
        if (btn_any) begin
          display_mode_d = 2'b00;
          state_d        = S_ENTER_A;
        end
      end
      default: state_d = S_ENTER_A;
    endcase
    alu_start_d = (state_d == S_START);
    busy_d      = (state_d == S_START) || (state_d == S_WAIT);
    error_d     = (state_d == S_ERR);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_ENTER_A;
      operand_a_q    <= '0;
      operand_b_q    <= '0;
      alu_op_q       <= '0;
      result_q       <= '0;
      display_mode_q <= 2'b00;
      cnt_q          <= '0;
      alu_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      operand_a_q    <= operand_a_d;
      operand_b_q    <= operand_b_d;
      alu_op_q       <= alu_op_d;
      result_q       <= result_d;
      display_mode_q <= display_mode_d;
      cnt_q          <= cnt_d;
      alu_start_q    <= alu_start_d;
      busy_q         <= busy_d;
      error_q        <= error_d;
    end
  end

  // Display mux: live switches while entering, result pages, or error pattern.
  always_comb begin
    bus.display_value = bus.bit_input;
    if (state_q == S_SHOW)
      bus.display_value = display_mode_q[0] ? result_q[2*DATA_W-1:DATA_W]
                                            : result_q[DATA_W-1:0];
    else if (state_q == S_ERR)
      bus.display_value = err_pattern();
  end

  assign bus.operand_a    = operand_a_q;
  assign bus.operand_b    = operand_b_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.alu_start    = alu_start_q;
  assign bus.display_mode = display_mode_q;
  assign bus.busy         = busy_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for the calculator sequencer: operand entry, ALU handshake,
// result paging, timeout/overflow errors, priority and async reset.
module tb_calc_op_sequencer;

  localparam int DATA_W  = 16;
  localparam int RES_W   = 32;
  localparam int TIMEOUT = 64;

  // Button masks {add, sub, mul, square, select}
  localparam logic [4:0] B_ADD = 5'b10000;
  localparam logic [4:0] B_SUB = 5'b01000;
  localparam logic [4:0] B_MUL = 5'b00100;
  localparam logic [4:0] B_SQ  = 5'b00010;
  localparam logic [4:0] B_SEL = 5'b00001;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   fails = 0;

  calc_op_sequencer_if #(.DATA_W(DATA_W), .RES_W(RES_W)) bus ();

  calc_op_sequencer #(.DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    bus.b_up_add_out         = b[4];
    bus.b_left_subtract_out  = b[3];
    bus.b_right_multiply_out = b[2];
    bus.b_down_square_out    = b[1];
    bus.b_mid_select_out     = b[0];
    tick();
    bus.b_up_add_out         = 1'b0;
    bus.b_left_subtract_out  = 1'b0;
    bus.b_right_multiply_out = 1'b0;
    bus.b_down_square_out    = 1'b0;
    bus.b_mid_select_out     = 1'b0;
  endtask

  task automatic alu_reply(input logic [31:0] res, input logic ovf);
    bus.alu_done   = 1'b1;
    bus.alu_result = res;
    bus.alu_ovf    = ovf;
    tick();
    bus.alu_done   = 1'b0;
    bus.alu_ovf    = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n                    = 1'b1;
    bus.bit_input            = 16'h00AA;
    bus.b_up_add_out         = 1'b0;
    bus.b_left_subtract_out  = 1'b0;
    bus.b_right_multiply_out = 1'b0;
    bus.b_down_square_out    = 1'b0;
    bus.b_mid_select_out     = 1'b0;
    bus.alu_done             = 1'b0;
    bus.alu_result           = '0;
    bus.alu_ovf              = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_opa", bus.operand_a, 0);
    chk("rst_opb", bus.operand_b, 0);
    chk("rst_op", bus.alu_op, 0);
    chk("rst_start", bus.alu_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.error, 0);
    chk("rst_mode", bus.display_mode, 0);
    chk("rst_disp", bus.display_value, 16'h00AA);
    rst_n = 1'b1;
    tick();

    // 5 + 3
    bus.bit_input = 16'h0005;
    press(B_SEL);
    chk("add_mode_b", bus.display_mode, 2'b01);
    chk("add_opa", bus.operand_a, 16'h0005);
    bus.bit_input = 16'h0003;
    press(B_ADD);
    chk("add_start", bus.alu_start, 1);
    chk("add_busy", bus.busy, 1);
    chk("add_opb", bus.operand_b, 16'h0003);
    chk("add_op", bus.alu_op, 2'b00);
    tick();
    chk("add_start_once", bus.alu_start, 0);
    chk("add_busy_wait", bus.busy, 1);
    alu_reply(32'h0000_0008, 1'b0);
    chk("add_mode_show", bus.display_mode, 2'b10);
    chk("add_disp", bus.display_value, 16'h0008);
    chk("add_busy_done", bus.busy, 0);

    // 0x1234 * 0x0100 with buttons pressed during the wait
    press(B_MUL);
    chk("show_exit_mode", bus.display_mode, 2'b00);
    bus.bit_input = 16'h1234;
    press(B_SEL);
    bus.bit_input = 16'h0100;
    press(B_MUL);
    chk("mul_op", bus.alu_op, 2'b10);
    tick();
    bus.bit_input = 16'hFFFF;
    press(5'b11111);
    chk("wait_ign_opa", bus.operand_a, 16'h1234);
    chk("wait_ign_opb", bus.operand_b, 16'h0100);
    chk("wait_ign_op", bus.alu_op, 2'b10);
    chk("wait_ign_busy", bus.busy, 1);
    chk("wait_ign_start", bus.alu_start, 0);
    alu_reply(32'h0012_3400, 1'b0);
    chk("mul_lo", bus.display_value, 16'h3400);
    press(B_SEL);
    chk("mul_mode_hi", bus.display_mode, 2'b11);
    chk("mul_hi", bus.display_value, 16'h0012);
    press(B_SEL);
    chk("mul_mode_lo", bus.display_mode, 2'b10);
    chk("mul_lo2", bus.display_value, 16'h3400);

    // Timeout: error exactly TIMEOUT cycles after entering S_WAIT
    press(B_ADD);
    bus.bit_input = 16'h0007;
    press(B_SEL);
    bus.bit_input = 16'h0002;
    press(B_SUB);
    chk("sub_op", bus.alu_op, 2'b01);
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("to_not_yet", bus.error, 0);
    chk("to_busy_yet", bus.busy, 1);
    tick();
    chk("to_err", bus.error, 1);
    chk("to_busy", bus.busy, 0);
    chk("to_disp", bus.display_value, 16'hEEEE);
    press(B_SQ);
    chk("to_clear", bus.error, 0);
    chk("to_mode", bus.display_mode, 2'b00);

    // mul+select together in S_ENTER_B, then overflow
    bus.bit_input = 16'h0011;
    press(B_SEL);
    bus.bit_input = 16'h0022;
    press(B_MUL | B_SEL);
    chk("pri_op", bus.alu_op, 2'b10);
    chk("pri_opa", bus.operand_a, 16'h0011);
    chk("pri_opb", bus.operand_b, 16'h0022);
    tick();
    alu_reply(32'hDEAD_BEEF, 1'b1);
    chk("ovf_err", bus.error, 1);
    chk("ovf_disp", bus.display_value, 16'hEEEE);
    press(B_ADD);
    chk("ovf_clear", bus.error, 0);

    // Done on the timeout cycle wins
    bus.bit_input = 16'h0009;
    press(B_SEL);
    bus.bit_input = 16'h0004;
    press(B_SQ);
    chk("sq_op", bus.alu_op, 2'b11);
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("race_pre", bus.error, 0);
    alu_reply(32'h0000_0051, 1'b0);
    chk("race_err", bus.error, 0);
    chk("race_mode", bus.display_mode, 2'b10);
    chk("race_disp", bus.display_value, 16'h0051);

    // Spurious done and operation button in S_ENTER_A are ignored
    press(B_ADD);
    bus.bit_input = 16'h0042;
    alu_reply(32'hFFFF_FFFF, 1'b0);
    chk("spur_mode", bus.display_mode, 2'b00);
    chk("spur_busy", bus.busy, 0);
    chk("spur_disp", bus.display_value, 16'h0042);
    press(B_SQ);
    chk("ea_op_ign_mode", bus.display_mode, 2'b00);
    chk("ea_op_ign_start", bus.alu_start, 0);

    // Asynchronous reset in the middle of S_WAIT
    bus.bit_input = 16'h0003;
    press(B_SEL);
    bus.bit_input = 16'h0006;
    press(B_ADD);
    tick();
    chk("ar_busy_pre", bus.busy, 1);
    bus.bit_input = 16'h0000;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_opa", bus.operand_a, 0);
    chk("ar_opb", bus.operand_b, 0);
    chk("ar_op", bus.alu_op, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_err", bus.error, 0);
    chk("ar_start", bus.alu_start, 0);
    chk("ar_mode", bus.display_mode, 0);
    chk("ar_disp", bus.display_value, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
